// File: rtl/lsu_stage_if.sv
// Execute-side request/response and data-memory bus of the load/store stage.
// master is the stage's view; slave is the execute/memory environment's view.
interface lsu_stage_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              memren_i;
    logic              memwren_i;
    logic [2:0]        funct3_i;
    logic [AWIDTH-1:0] addr_i;
    logic [DWIDTH-1:0] store_data_i;
    logic              resp_valid_o;
    logic [DWIDTH-1:0] load_data_o;
    logic              err_o;
    logic              stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [DWIDTH-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DWIDTH-1:0] mem_rdata_i;

    modport master (
        input  req_valid_i, memren_i, memwren_i, funct3_i, addr_i, store_data_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, load_data_o, err_o, stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        output req_valid_i, memren_i, memwren_i, funct3_i, addr_i, store_data_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, load_data_o, err_o, stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_stage.sv
// RV32I load/store stage: one lane-aligned access per operation over a req/gnt/rvalid port.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | mem_req_o asserted, waiting for grant
// WAIT  | load granted, waiting for read data
// RESP  | one-cycle completion pulse to writeback
module lsu_stage #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    lsu_stage_if.master  bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic [DWIDTH-1:0] sdata_q;
    logic [DWIDTH-1:0] ldata_q;
    logic              err_q;

    logic              accept;
    logic              is_mem;
    logic              misalign;
    logic              capture;
    logic [1:0]        size_in;
    logic [1:0]        size_q;
    logic [1:0]        off;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] extracted;

    // 0 byte, 1 half, 2 word; unlisted store encodings behave as SW
    function automatic logic [1:0] size_of(input logic st, input logic [2:0] f3);
        if (st)
            return (f3 == 3'b000) ? 2'd0 : (f3 == 3'b001) ? 2'd1 : 2'd2;
        else
            return (f3[1:0] == 2'b00) ? 2'd0 : (f3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    endfunction

    assign accept  = (state == IDLE) && bus.req_valid_i;
    assign is_mem  = bus.memren_i || bus.memwren_i;
    assign size_in = size_of(bus.memwren_i, bus.funct3_i);
    assign size_q  = size_of(store_q, funct3_q);
    assign off     = addr_q[1:0];
    assign capture = !store_q && bus.mem_rvalid_i &&
                     (((state == REQ) && bus.mem_gnt_i) || (state == WAIT));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_mem && (((size_in == 2'd1) && bus.addr_i[0]) ||
                                 ((size_in == 2'd2) && (bus.addr_i[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0: byte_sel = bus.mem_rdata_i[7:0];
            2'd1: byte_sel = bus.mem_rdata_i[15:8];
            2'd2: byte_sel = bus.mem_rdata_i[23:16];
            2'd3: byte_sel = bus.mem_rdata_i[31:24];
        endcase
        half_sel  = off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        extracted = bus.mem_rdata_i;
        if (size_q == 2'd0)
            extracted = funct3_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (size_q == 2'd1)
            extracted = funct3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            sdata_q  <= '0;
            ldata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q   <= bus.addr_i;
                funct3_q <= bus.funct3_i;
                store_q  <= bus.memwren_i;
                sdata_q  <= bus.store_data_i;
                ldata_q  <= '0;
                err_q    <= misalign;
            end else if (capture) begin
                ldata_q <= extracted;
            end
        end
    end

    always_comb begin
        state_nx         = state;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_be_o     = 4'h0;
        bus.mem_wdata_o  = '0;
        case (state)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i)
                    state_nx = (is_mem && !misalign) ? REQ : RESP;
            end
            REQ: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_we_o   = store_q;
                bus.mem_addr_o = {addr_q[AWIDTH-1:2], 2'b00};
                bus.mem_be_o   = 4'hF;
                if (store_q) begin
                    case (size_q)
                        2'd0: begin
                            bus.mem_be_o    = 4'b0001 << off;
                            bus.mem_wdata_o = {4{sdata_q[7:0]}};
                        end
                        2'd1: begin
                            bus.mem_be_o    = off[1] ? 4'b1100 : 4'b0011;
                            bus.mem_wdata_o = {2{sdata_q[15:0]}};
                        end
                        default: bus.mem_wdata_o = sdata_q;
                    endcase
                end
                if (bus.mem_gnt_i)
                    state_nx = (store_q || bus.mem_rvalid_i) ? RESP : WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid_i)
                    state_nx = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.load_data_o = ldata_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (state != IDLE);

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage; inputs driven and outputs sampled on negedge.
module tb_lsu_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_stage_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    lsu_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic st, input logic ldop, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] ld_exp, input int lat_exp, input string tag);
        int lat;
        logic [31:0] maddr;
        maddr = {a[31:2], 2'b00};
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.memren_i     = ldop;
        bus.memwren_i    = st;
        bus.funct3_i     = f3;
        bus.addr_i       = a;
        bus.store_data_i = sd;
        @(negedge clk);
        lat = 1;
        bus.req_valid_i  = 1'b0;
        bus.memren_i     = 1'b0;
        bus.memwren_i    = 1'b0;
        bus.addr_i       = '0;
        bus.store_data_i = '0;
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'd1);
        chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd0);
        if (st || ldop) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                chk({tag, "_req"}, 32'(bus.mem_req_o), 32'd1);
                chk({tag, "_we"}, 32'(bus.mem_we_o), 32'(st));
                chk({tag, "_addr"}, bus.mem_addr_o, maddr);
                chk({tag, "_be"}, 32'(bus.mem_be_o), 32'(be));
                if (st) chk({tag, "_wdata"}, bus.mem_wdata_o, wd);
                if (i == gnt_dly) begin
                    bus.mem_gnt_i = 1'b1;
                    if (!st && rv_dly == 0) begin
                        bus.mem_rvalid_i = 1'b1;
                        bus.mem_rdata_i  = rdata;
                    end
                end
                @(negedge clk);
                lat++;
            end
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = '0;
            if (!st && rv_dly > 0) begin
                for (int j = 1; j < rv_dly; j++) begin
                    chk({tag, "_wait_stall"}, 32'(bus.stall_o), 32'd1);
                    chk({tag, "_wait_ready"}, 32'(bus.req_ready_o), 32'd0);
                    chk({tag, "_wait_resp"}, 32'(bus.resp_valid_o), 32'd0);
                    chk({tag, "_wait_req"}, 32'(bus.mem_req_o), 32'd0);
                    @(negedge clk);
                    lat++;
                end
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = rdata;
                @(negedge clk);
                lat++;
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = '0;
            end
        end
        chk({tag, "_resp"}, 32'(bus.resp_valid_o), 32'd1);
        chk({tag, "_ldata"}, bus.load_data_o, ld_exp);
        chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_req_off"}, 32'(bus.mem_req_o), 32'd0);
        @(negedge clk);
        chk({tag, "_resp_off"}, 32'(bus.resp_valid_o), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready_o), 32'd1);
        chk({tag, "_stall_off"}, 32'(bus.stall_o), 32'd0);
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.memren_i     = 1'b0;
        bus.memwren_i    = 1'b0;
        bus.funct3_i     = 3'b000;
        bus.addr_i       = '0;
        bus.store_data_i = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_resp", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_ldata", bus.load_data_o, 32'd0);

        run_op(1'b1, 1'b0, 3'b010, 32'h0100_0008, 32'hDEAD_BEEF, 2, 0, 32'h0,
               4'b1111, 32'hDEAD_BEEF, 32'h0, 4, "sw");
        run_op(1'b1, 1'b0, 3'b000, 32'h0100_0003, 32'h0000_00A5, 0, 0, 32'h0,
               4'b1000, 32'hA5A5_A5A5, 32'h0, 2, "sb");
        // both memren and memwren set: the store takes priority
        run_op(1'b1, 1'b1, 3'b001, 32'h0100_0002, 32'h0000_1234, 1, 0, 32'h0,
               4'b1100, 32'h1234_1234, 32'h0, 3, "sh_both");
        run_op(1'b0, 1'b1, 3'b000, 32'h0100_0006, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'hFFFF_FFF1, 2, "lb");
        run_op(1'b0, 1'b1, 3'b100, 32'h0100_0006, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'h0000_00F1, 2, "lbu");
        run_op(1'b0, 1'b1, 3'b001, 32'h0100_0006, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'hFFFF_80F1, 2, "lh");
        run_op(1'b0, 1'b1, 3'b101, 32'h0100_0006, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'h0000_80F1, 2, "lhu");
        run_op(1'b0, 1'b1, 3'b000, 32'h0100_0001, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'h0000_007F, 2, "lb_off1");
        run_op(1'b0, 1'b1, 3'b010, 32'h0100_0010, 32'h0, 0, 3, 32'h1357_9BDF,
               4'b1111, 32'h0, 32'h1357_9BDF, 5, "lw_slow");
        run_op(1'b0, 1'b0, 3'b010, 32'h0100_0010, 32'h0, 0, 0, 32'h0,
               4'b0000, 32'h0, 32'h0, 1, "nop");

        // reset while a load waits for data, then a stale rvalid/gnt in IDLE
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.memren_i    = 1'b1;
        bus.funct3_i    = 3'b010;
        bus.addr_i      = 32'h0100_0020;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.memren_i    = 1'b0;
        bus.mem_gnt_i   = 1'b1;
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        chk("rstw_stall", 32'(bus.stall_o), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rstw_ready", 32'(bus.req_ready_o), 32'd1);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rdata_i  = '0;
        chk("rstw_resp", 32'(bus.resp_valid_o), 32'd0);
        chk("rstw_stall_off", 32'(bus.stall_o), 32'd0);
        chk("rstw_req", 32'(bus.mem_req_o), 32'd0);
        chk("rstw_ldata", bus.load_data_o, 32'd0);
        @(negedge clk);
        chk("rstw_resp2", 32'(bus.resp_valid_o), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.memren_i    = 1'b1;
        bus.funct3_i    = 3'b010;
        bus.addr_i      = 32'h0100_0002;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.memren_i    = 1'b0;
        chk("trap_lw_req", 32'(bus.mem_req_o), 32'd0);
        chk("trap_lw_resp", 32'(bus.resp_valid_o), 32'd1);
        chk("trap_lw_err", 32'(bus.err_o), 32'd1);
        chk("trap_lw_ldata", bus.load_data_o, 32'd0);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.memwren_i    = 1'b1;
        bus.funct3_i     = 3'b001;
        bus.addr_i       = 32'h0100_0001;
        bus.store_data_i = 32'h0000_5555;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.memwren_i   = 1'b0;
        chk("trap_sh_req", 32'(bus.mem_req_o), 32'd0);
        chk("trap_sh_resp", 32'(bus.resp_valid_o), 32'd1);
        chk("trap_sh_err", 32'(bus.err_o), 32'd1);
        @(negedge clk);
        chk("trap_sh_ready", 32'(bus.req_ready_o), 32'd1);
`else
        run_op(1'b0, 1'b1, 3'b010, 32'h0100_0002, 32'h0, 0, 0, 32'h1122_3344,
               4'b1111, 32'h0, 32'h1122_3344, 2, "lw_trunc");
        run_op(1'b0, 1'b1, 3'b001, 32'h0100_0003, 32'h0, 0, 0, 32'h80F1_7F02,
               4'b1111, 32'h0, 32'hFFFF_80F1, 2, "lh_trunc");
        run_op(1'b1, 1'b0, 3'b001, 32'h0100_0001, 32'h0000_5AC3, 0, 0, 32'h0,
               4'b0011, 32'h5AC3_5AC3, 32'h0, 2, "sh_trunc");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit sitting directly downstream of the ALU in the RV32I datapath.
- Consumes the ALU effective address, the memory control bits and rs2 data.
- Performs one byte-lane-aligned access to a request/grant/rvalid data-memory port.
- Returns sign- or zero-extended load data to writeback and asserts stall_o while an access is in flight.
- Replaces the combinational associative-array data memory with a handshaked, multi-cycle stage.

Parameters:
- AWIDTH, 32, address width in bits.
- DWIDTH, 32, data width in bits; only 32 is supported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- req_valid_i  input  1  execute stage presents an operation
- req_ready_o  output  1  stage can accept an operation
- memren_i  input  1  load
- memwren_i  input  1  store
- funct3_i  input  3  access size/sign (RV32I load/store encoding)
- addr_i  input  AWIDTH  byte effective address from ALU
- store_data_i  input  DWIDTH  rs2 value
- resp_valid_o  output  1  one-cycle completion pulse
- load_data_o  output  DWIDTH  extended load result; valid with resp_valid_o
- err_o  output  1  misaligned access flag; valid with resp_valid_o
- stall_o  output  1  stage busy; upstream must hold
- mem_req_o  output  1  memory request
- mem_we_o  output  1  write request
- mem_addr_o  output  AWIDTH  word-aligned address, addr[1:0] forced to 0
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  DWIDTH  lane-replicated store data
- mem_gnt_i  input  1  request accepted
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  DWIDTH  read word

Behaviour:
- Reset is synchronous and active-low: reset==0 at posedge clk forces state IDLE. All outputs are 0 except req_ready_o=1. Captured registers are cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Operation accepted on req_valid_i&&req_ready_o. Addr, funct3, op type and store data are captured.
  - Store wins if memren_i and memwren_i are both 1.
  - Neither set: go to RESP, load_data 0 (1-cycle pass-through).
  - Otherwise: go to REQ.
- REQ:
  - mem_req_o=1.
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i.
  - On gnt, a store goes to RESP.
  - On gnt, a load goes to WAIT, or straight to RESP if mem_rvalid_i is in the same cycle (rdata captured).
- WAIT: on mem_rvalid_i, capture the extracted data and go to RESP. No timeout.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0 in RESP.
- stall_o = (state != IDLE). Minimum load latency is accept→resp_valid of 2 cycles, with gnt and rvalid in the same cycle.
- Byte enables, with off = addr[1:0]:
  - SB: 4'b0001<<off, wdata={4{rs2[7:0]}}.
  - SH: 4'b0011<<(2*off[1]), wdata={2{rs2[15:0]}}.
  - SW: 4'b1111.
  - Other store funct3 are treated as SW.
- Load extract from the captured word:
  - LB/LBU: byte at off, sign-/zero-extended.
  - LH/LHU: half at off[1], sign-/zero-extended.
  - LW and undefined funct3: full word.
- Loads drive mem_be_o=4'b1111.
- mem_rvalid_i or mem_gnt_i arriving while in IDLE/RESP is ignored. This covers a stale response after reset.
- Reset mid-operation abandons the access. There is no retry and no resp_valid_o.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with off[0]=1, or a word with off!=0, issues no memory request.
  - It goes IDLE→RESP with err_o=1 and load_data_o=0. A store writes nothing.
- Undefined:
  - err_o is tied 0.
  - Misaligned accesses are truncated to natural alignment: halfword uses off[1], word uses aligned word.

Test Plan:
- Reset held low 2 cycles, then reset=1 → req_ready_o=1; mem_req_o, resp_valid_o and stall_o all 0.
- SW addr=0x01000008, data=0xDEADBEEF, gnt after 2 cycles → mem_addr_o=0x01000008, be=1111, wdata=0xDEADBEEF held stable; resp_valid_o one cycle after gnt.
- SB addr=0x01000003, data=0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- Loads with rdata=0x80F17F02, off=2, where gnt and rvalid are in the same cycle → LB=0xFFFFFFF1; LBU=0x000000F1; LH=0xFFFF80F1; LHU=0x000080F1; resp exactly 2 cycles after accept.
- LW with gnt, rvalid 3 cycles later → stall_o high throughout; load_data_o=rdata; req_ready_o low until return to IDLE.
- Reset pulsed in WAIT, then stale rvalid → no resp_valid_o. With LSU_MISALIGN_TRAP_EN: LW addr=0x01000002 → no mem_req_o, err_o=1 with resp_valid_o.
